// File: rtl/shift_counter_pkg.sv
// Shared encodings and reset pattern for the parametrised Johnson/ring shift counter.
package shift_counter_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

  // Step 0 of both sequences is a single one in bit 0, whatever the width.
  function automatic logic [31:0] reset_pattern(input int unsigned width);
    return (width == 0) ? 32'd0 : 32'd1;
  endfunction

endpackage

// File: rtl/shift_counter_param_if.sv
// Control and status bundle between a sequencer user (master) and the shift counter (slave).
interface shift_counter_param_if #(
  parameter int WIDTH = 4
);
  localparam int IW = $clog2(2 * WIDTH);

  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [IW-1:0]    index;
  logic             illegal;
  logic             tc;

  modport master (
    output en, dir, mode, load, load_val,
    input  count, index, illegal, tc
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output count, index, illegal, tc
  );

endinterface

// File: rtl/shift_counter_decode.sv
// Combinational decode of the counter register: legality for the current mode and step index.
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             mode_i,
  output logic [IW-1:0]    index_o,
  output logic             illegal_o
);

  localparam int PW = $clog2(WIDTH + 1);

  logic [PW-1:0] ones;
  logic [PW-1:0] trans;
  logic [IW-1:0] ring_pos;
  logic [IW-1:0] john_idx;
  logic          ring_ok;
  logic          john_ok;

  always_comb begin
    ones     = '0;
    trans    = '0;
    ring_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + PW'(count_i[i]);
      if (count_i[i]) ring_pos = IW'(i);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      trans = trans + PW'(count_i[i] ^ count_i[i+1]);
    end
  end

  // A Johnson state is a thermometer code: at most one adjacent-bit edge.
  assign john_ok = (trans <= PW'(1));
  assign ring_ok = (ones == PW'(1));

  // Filling phase (bit 0 set) counts ones upward; draining phase counts them back down.
  assign john_idx = count_i[0] ? (IW'(ones) - IW'(1))
                               : (IW'(2 * WIDTH - 1) - IW'(ones));

  always_comb begin
    illegal_o = (mode_i == MODE_RING) ? !ring_ok : !john_ok;
    index_o   = '0;
    if (!illegal_o) index_o = (mode_i == MODE_RING) ? ring_pos : john_idx;
  end

endmodule

// File: rtl/shift_counter_param.sv
// Johnson/ring shift counter: state register, next-state selection and terminal-count flag.
module shift_counter_param
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_counter_param_if.slave  bus
);

  localparam int IW = $clog2(2 * WIDTH);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(reset_pattern(WIDTH));

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] step_val;
  logic [IW-1:0]    index;
  logic [IW-1:0]    last_idx;
  logic             illegal;

  shift_counter_decode #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_decode (
    .count_i   (count_q),
    .mode_i    (bus.mode),
    .index_o   (index),
    .illegal_o (illegal)
  );

  always_comb begin
    step_val = count_q;
    unique case ({bus.mode, bus.dir})
      {MODE_JOHNSON, DIR_UP}:   step_val = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      {MODE_JOHNSON, DIR_DOWN}: step_val = {~count_q[0], count_q[WIDTH-1:1]};
      {MODE_RING, DIR_UP}:      step_val = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
      {MODE_RING, DIR_DOWN}:    step_val = {count_q[0], count_q[WIDTH-1:1]};
      default:                  step_val = count_q;
    endcase
  end

  // An illegal state never steps: it snaps back to step 0 so the sequence self-heals.
  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.en) begin
      count_d = illegal ? RST_VAL : step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= RST_VAL;
    else       count_q <= count_d;
  end

  assign last_idx = (bus.mode == MODE_RING) ? IW'(WIDTH - 1) : IW'(2 * WIDTH - 1);

  assign bus.count   = count_q;
  assign bus.index   = index;
  assign bus.illegal = illegal;
  assign bus.tc      = bus.en & !bus.load & !illegal &
                       ((!bus.dir & (index == last_idx)) | (bus.dir & (index == '0)));

endmodule

// File: tb/tb_shift_counter_param.sv
// Bench: four widths driven in lockstep, checked every cycle against a sequence-table model.
module tb_shift_counter_param;
  import shift_counter_pkg::*;

  localparam int NI = 4;
  localparam int WS [NI] = '{4, 2, 5, 32};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
  logic [31:0] lv    [NI];
  logic [31:0] d_cnt [NI];
  logic [31:0] d_idx [NI];
  logic        d_ill [NI];
  logic        d_tc  [NI];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : gi
      localparam int W = WS[g];
      shift_counter_param_if #(.WIDTH(W)) bus ();
      assign bus.en       = en;
      assign bus.dir      = dir;
      assign bus.mode     = mode;
      assign bus.load     = load;
      assign bus.load_val = lv[g][W-1:0];
      shift_counter_param #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
      );
      assign d_cnt[g] = 32'(bus.count);
      assign d_idx[g] = 32'(bus.index);
      assign d_ill[g] = bus.illegal;
      assign d_tc[g]  = bus.tc;
    end
  endgenerate

  // Model: the k-th state of each sequence is built directly, legality is table lookup.
  function automatic logic [31:0] pat(input int w, input logic m, input int k);
    logic [63:0] v;
    int ones;
    if (m) v = 64'd1 << k;
    else if (k < w) v = (64'd1 << (k + 1)) - 64'd1;
    else begin
      ones = 2 * w - 1 - k;
      v = ((64'd1 << ones) - 64'd1) << (w - ones);
    end
    return v[31:0];
  endfunction

  function automatic int nstates(input int w, input logic m);
    return m ? w : 2 * w;
  endfunction

  function automatic int lookup(input int w, input logic m, input logic [31:0] c);
    for (int k = 0; k < nstates(w, m); k++) if (pat(w, m, k) == c) return k;
    return -1;
  endfunction

  function automatic logic [31:0] mask(input int w);
    logic [63:0] v;
    v = (64'd1 << w) - 64'd1;
    return v[31:0];
  endfunction

  function automatic logic [31:0] next_cnt(input int w, input logic [31:0] c, input logic r,
                                           input logic l, input logic e, input logic m,
                                           input logic d, input logic [31:0] v);
    int k, n;
    if (r) return 32'd1;
    if (l) return v & mask(w);
    if (!e) return c;
    k = lookup(w, m, c);
    n = nstates(w, m);
    if (k < 0) return 32'd1;
    return pat(w, m, d ? (k + n - 1) % n : (k + 1) % n);
  endfunction

  logic [31:0] m_cnt [NI];
  logic        started = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++)
      m_cnt[i] <= next_cnt(WS[i], m_cnt[i], reset, load, en, mode, dir, lv[i]);
    if (reset) started <= 1'b1;
  end

  int total = 0;
  int bad   = 0;

  logic       lit_en  = 1'b0;
  logic [3:0] lit_cnt = 4'd0;
  int         lit_idx = 0;
  logic       lit_ill = 1'b0;
  logic       lit_tc  = 1'b0;

  task automatic check(input string nm, input int w, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s w=%0d t=%0t got=%h want=%h", nm, w, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < NI; i++) begin
        int k, n;
        logic etc;
        k = lookup(WS[i], mode, m_cnt[i]);
        n = nstates(WS[i], mode);
        etc = en && !load && (k >= 0) && ((!dir && k == n - 1) || (dir && k == 0));
        check("count", WS[i], d_cnt[i], m_cnt[i]);
        check("index", WS[i], d_idx[i], (k < 0) ? 32'd0 : 32'(k));
        check("illegal", WS[i], 32'(d_ill[i]), 32'(k < 0));
        check("tc", WS[i], 32'(d_tc[i]), 32'(etc));
      end
      if (lit_en) begin
        check("lit_count", 4, d_cnt[0], 32'(lit_cnt));
        check("lit_index", 4, d_idx[0], 32'(lit_idx));
        check("lit_illegal", 4, 32'(d_ill[0]), 32'(lit_ill));
        check("lit_tc", 4, 32'(d_tc[0]), 32'(lit_tc));
      end
    end
  end

  // Inputs apply for one edge; the literal describes W=4 outputs seen just before that edge.
  task automatic step(input logic r, input logic e, input logic d, input logic m, input logic l,
                      input logic [3:0] v4, input logic chk, input logic [3:0] c,
                      input int ix, input logic il, input logic t);
    reset = r; en = e; dir = d; mode = m; load = l;
    lv[0] = 32'(v4);
    for (int i = 1; i < NI; i++) lv[i] = $urandom;
    lit_en = chk; lit_cnt = c; lit_idx = ix; lit_ill = il; lit_tc = t;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic r, input logic e, input logic d, input logic m, input logic l);
    step(r, e, d, m, l, 4'($urandom), 1'b0, 4'd0, 0, 1'b0, 1'b0);
  endtask

  logic [3:0] jseq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] rseq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    for (int i = 0; i < NI; i++) lv[i] = '0;
    #1;
    // reset wins over load and en on the same edge
    step(1, 1, 0, 0, 1, 4'b0101, 0, 4'd0, 0, 0, 0);
    // Johnson up through the full cycle; tc only at 0000
    for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0, 4'd0, 1, jseq[k], k, 0, k == 7);
    // Johnson down from 0001 wraps to 0000, then 1000
    step(0, 1, 1, 0, 0, 4'd0, 1, 4'b0001, 0, 0, 1);
    step(0, 1, 1, 0, 0, 4'd0, 1, 4'b0000, 7, 0, 0);
    step(0, 0, 1, 0, 0, 4'd0, 1, 4'b1000, 6, 0, 0);
    step(1, 0, 0, 0, 0, 4'd0, 1, 4'b1000, 6, 0, 0);
    // ring up, tc at 1000; then ring down from 0001 to 1000
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1, 0, 4'd0, 1, rseq[k], k, 0, k == 3);
    step(0, 1, 1, 1, 0, 4'd0, 1, 4'b0001, 0, 0, 1);
    step(0, 0, 1, 1, 0, 4'd0, 1, 4'b1000, 3, 0, 0);
    // illegal load holds until enabled, then recovers
    step(0, 1, 0, 1, 1, 4'b0101, 1, 4'b1000, 3, 0, 0);
    step(0, 0, 0, 1, 0, 4'd0, 1, 4'b0101, 0, 1, 0);
    step(0, 1, 1, 1, 0, 4'd0, 1, 4'b0101, 0, 1, 0);
    step(0, 0, 0, 1, 0, 4'd0, 1, 4'b0001, 0, 0, 0);
    // Johnson 0011 becomes illegal under ring and recovers to 0001
    step(0, 1, 0, 0, 0, 4'd0, 1, 4'b0001, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4'd0, 1, 4'b0011, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'd0, 1, 4'b0011, 0, 1, 0);
    step(0, 1, 0, 1, 0, 4'd0, 1, 4'b0011, 0, 1, 0);
    step(0, 0, 0, 1, 0, 4'd0, 1, 4'b0001, 0, 0, 0);
    // reset mid-run with en and load asserted
    for (int k = 0; k < 5; k++) run(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1, 4'b1111, 1, 4'b1100, 5, 0, 0);
    step(0, 0, 0, 0, 0, 4'd0, 1, 4'b0001, 0, 0, 0);
    // width sweep: 2*WIDTH full Johnson cycles of the widest instance, then other modes
    for (int k = 0; k < 4 * 32 * 32; k++) run(0, 1, 0, 0, 0);
    for (int k = 0; k < 256; k++) run(0, 1, 1, 0, 0);
    for (int k = 0; k < 256; k++) run(0, 1, 0, 1, 0);
    for (int k = 0; k < 256; k++) run(0, 1, 1, 1, 0);
    // mixed traffic: dir every cycle, occasional mode flips, loads and resets
    for (int k = 0; k < 2000; k++) begin
      logic m;
      m = mode ^ ($urandom_range(15) == 0);
      run($urandom_range(99) == 0, $urandom_range(3) != 0, 1'($urandom), m,
          $urandom_range(19) == 0);
    end
    run(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
